// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, their codes and
// the word-aligner state encoding.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    localparam logic [1:0] CODE_C00 = 2'b00;
    localparam logic [1:0] CODE_C01 = 2'b01;
    localparam logic [1:0] CODE_C10 = 2'b10;
    localparam logic [1:0] CODE_C11 = 2'b11;

    typedef enum logic {
        SEARCH,
        LOCKED
    } align_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } tok_match_t;

    function automatic tok_match_t tok_match(input logic [9:0] w);
        tok_match_t t;
        t.hit  = 1'b1;
        t.code = CODE_C00;
        case (w)
            TOK_C00: t.code = CODE_C00;
            TOK_C01: t.code = CODE_C01;
            TOK_C10: t.code = CODE_C10;
            TOK_C11: t.code = CODE_C11;
            default: t.hit = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_word_align_bitslip_10b.sv
// Combinational 20-to-10 bit selector; offset 0 picks the older word.
module bitslip_10b (
    input  logic [19:0] cat_i,
    input  logic [3:0]  offset_i,
    output logic [9:0]  word_o
);

    always_comb begin
        word_o = cat_i[9:0];
        case (offset_i)
            4'd0:    word_o = cat_i[9:0];
            4'd1:    word_o = cat_i[10:1];
            4'd2:    word_o = cat_i[11:2];
            4'd3:    word_o = cat_i[12:3];
            4'd4:    word_o = cat_i[13:4];
            4'd5:    word_o = cat_i[14:5];
            4'd6:    word_o = cat_i[15:6];
            4'd7:    word_o = cat_i[16:7];
            4'd8:    word_o = cat_i[17:8];
            4'd9:    word_o = cat_i[18:9];
            default: word_o = cat_i[9:0];
        endcase
    end

endmodule

// File: rtl/tmds_word_align.sv
// TMDS symbol boundary recovery: scans bit offsets for control-token
// runs, locks on one, and emits aligned symbols with token decode.
import tmds_pkg::*;

module tmds_word_align #(
    parameter int LOCK_CNT    = 8,
    parameter int SEARCH_WAIT = 4096,
    parameter int LOSS_WAIT   = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    output logic [9:0] data_out,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int DW = $clog2(SEARCH_WAIT);
    localparam int LW = $clog2(LOSS_WAIT);

    align_state_e state_q;
    logic [9:0]   prev_q;
    logic [9:0]   data_q;
    logic         cv_q;
    logic [1:0]   ctrl_q;
    logic         locked_q;
    logic [3:0]   offset_q;
    logic [RW-1:0] run_q;
    logic [DW-1:0] dwell_q;
    logic [LW-1:0] loss_q;

    logic [9:0]    word;
    tok_match_t    tm;
    logic [RW-1:0] run_inc;
    logic [RW-1:0] run_d;
    logic          qual;

    bitslip_10b u_slip (
        .cat_i    ({data_in, prev_q}),
        .offset_i (offset_q),
        .word_o   (word)
    );

    // run count saturates so a long blanking run keeps qualifying
    always_comb begin
        tm      = tok_match(word);
        run_inc = (run_q == RW'(LOCK_CNT)) ? run_q : run_q + RW'(1);
        run_d   = tm.hit ? run_inc : '0;
        qual    = tm.hit && (run_inc == RW'(LOCK_CNT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            prev_q   <= '0;
            data_q   <= '0;
            cv_q     <= 1'b0;
            ctrl_q   <= '0;
            locked_q <= 1'b0;
            offset_q <= '0;
            run_q    <= '0;
            dwell_q  <= '0;
            loss_q   <= '0;
        end else begin
            prev_q <= data_in;
            data_q <= word;
            cv_q   <= tm.hit;
            ctrl_q <= tm.hit ? tm.code : 2'b00;
            run_q  <= run_d;
            unique case (state_q)
                SEARCH: begin
                    if (qual) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        dwell_q  <= '0;
                        loss_q   <= '0;
                    end else if (dwell_q == DW'(SEARCH_WAIT - 1)) begin
                        offset_q <= (offset_q == 4'd9) ? 4'd0
                                                       : offset_q + 4'd1;
                        dwell_q  <= '0;
                        run_q    <= '0;
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                LOCKED: begin
                    if (qual) begin
                        loss_q <= '0;
                    end else if (loss_q == LW'(LOSS_WAIT - 1)) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                        dwell_q  <= '0;
                        loss_q   <= '0;
                    end else begin
                        loss_q <= loss_q + LW'(1);
                    end
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign ctrl_valid = cv_q;
    assign ctrl       = ctrl_q;
    assign locked     = locked_q;
    assign offset     = offset_q;

endmodule

// File: tb/tb_tmds_word_align.sv
// Directed and randomized checks of tmds_word_align against a
// bit-stream reference model.
module tb_tmds_word_align;

    localparam int LC = 4;
    localparam int SW = 16;
    localparam int LWT = 64;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] data_in = '0;
    logic [9:0] data_out;
    logic       ctrl_valid;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;

    int checks = 0;
    int errors = 0;

    logic [9:0] m_prev;
    int         m_off, m_run, m_dwell, m_loss;
    logic       m_lock;
    logic [9:0] e_data;
    logic       e_cv;
    logic [1:0] e_ctrl;
    logic [9:0] psym;

    tmds_word_align #(
        .LOCK_CNT    (LC),
        .SEARCH_WAIT (SW),
        .LOSS_WAIT   (LWT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .ctrl_valid (ctrl_valid),
        .ctrl       (ctrl),
        .locked     (locked),
        .offset     (offset)
    );

    always #5 clk = ~clk;

    function automatic int tok_index(input logic [9:0] w);
        if (w == T0) return 0;
        if (w == T1) return 1;
        if (w == T2) return 2;
        if (w == T3) return 3;
        return -1;
    endfunction

    // word whose bits [k+9:k] of {word, prev} form sym when chained
    function automatic logic [9:0] skew(input logic [9:0] sym,
                                        input logic [9:0] ps,
                                        input int k);
        logic [19:0] c;
        c = {sym, ps};
        c = c >> (10 - k);
        return c[9:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input logic [9:0] din, input logic rst);
        logic [19:0] c;
        logic [9:0]  w;
        int          t;
        int          rn;
        if (!rst) begin
            m_prev = '0; m_off = 0; m_run = 0; m_dwell = 0;
            m_loss = 0; m_lock = 1'b0;
            e_data = '0; e_cv = 1'b0; e_ctrl = '0;
        end else begin
            c = {din, m_prev};
            c = c >> m_off;
            w = c[9:0];
            t = tok_index(w);
            rn = (t >= 0) ? ((m_run + 1 > LC) ? LC : m_run + 1) : 0;
            e_data = w;
            e_cv = (t >= 0);
            e_ctrl = (t >= 0) ? 2'(t) : 2'b00;
            if (!m_lock) begin
                if (t >= 0 && m_run + 1 >= LC) begin
                    m_lock = 1'b1; m_dwell = 0; m_loss = 0; m_run = rn;
                end else if (m_dwell == SW - 1) begin
                    m_off = (m_off + 1) % 10; m_dwell = 0; m_run = 0;
                end else begin
                    m_dwell++; m_run = rn;
                end
            end else begin
                m_run = rn;
                if (rn == LC) m_loss = 0;
                else if (m_loss == LWT - 1) begin
                    m_lock = 1'b0; m_run = 0; m_dwell = 0; m_loss = 0;
                end else m_loss++;
            end
            m_prev = din;
        end
    endtask

    task automatic step(input logic [9:0] din, input logic rst);
        data_in = din;
        rst_n = rst;
        model_tick(din, rst);
        @(posedge clk);
        #1;
        chk("model_data_out", data_out, e_data);
        chk("model_ctrl_valid", ctrl_valid, e_cv);
        chk("model_ctrl", ctrl, e_ctrl);
        chk("model_locked", locked, m_lock);
        chk("model_offset", offset, m_off);
    endtask

    task automatic send_skew(input logic [9:0] sym, input int k);
        step(skew(sym, psym, k), 1'b1);
        psym = sym;
    endtask

    initial begin
        logic [9:0] d, last;
        int n, cnt;
        logic ever;

        // reset state
        step(10'h3FF, 1'b0);
        step(10'h3FF, 1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_offset", offset, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ctrl_valid", ctrl_valid, 0);
        chk("rst_ctrl", ctrl, 0);

        // aligned stream
        for (int i = 0; i < 4; i++) step(T0, 1'b1);
        chk("aligned_pre_lock", locked, 0);
        d = 10'($urandom_range(0, 1023));
        step(d, 1'b1);
        chk("aligned_lock", locked, 1);
        chk("aligned_offset", offset, 0);
        chk("aligned_data_out", data_out, T0);
        for (int i = 0; i < 6; i++) begin
            last = d;
            d = 10'($urandom_range(0, 1023));
            step(d, 1'b1);
            chk("aligned_delay2", data_out, last);
        end

        // 3-bit skew, 4-token run every 12 symbols
        step(10'h000, 1'b0);
        psym = '0;
        n = 0;
        while (!locked && n < 200) begin
            n++;
            send_skew(((n - 1) % 12 < 4) ? T0 : 10'h000, 3);
            if (n == 16) chk("skew_off1", offset, 1);
            if (n == 32) chk("skew_off2", offset, 2);
            if (n == 48) chk("skew_off3", offset, 3);
            if (n == 47) chk("skew_unlocked", locked, 0);
        end
        chk("skew_lock", locked, 1);
        chk("skew_lock_off", offset, 3);

        // loss of lock on continuous data
        cnt = 0;
        while (locked && cnt < 200) begin
            step(10'h2AA, 1'b1);
            cnt++;
        end
        chk("loss_cycles", cnt, 64);
        chk("loss_offset", offset, 3);
        for (int i = 0; i < 15; i++) step(10'h2AA, 1'b1);
        chk("loss_dwell_hold", offset, 3);
        step(10'h2AA, 1'b1);
        chk("loss_dwell_adv", offset, 4);

        // runs of three tokens never lock; offset wraps
        step(10'h000, 1'b0);
        ever = 1'b0;
        for (int i = 1; i <= 160; i++) begin
            step(((i - 1) % 4 < 3) ? T0 : 10'h000, 1'b1);
            ever = ever | locked;
            if (i == 144) chk("wrap_off9", offset, 9);
        end
        chk("wrap_off0", offset, 0);
        chk("wrap_never_locked", ever, 0);

        // token decode
        step(10'h000, 1'b0);
        step(T2, 1'b1);
        step(10'h155, 1'b1);
        chk("dec_data", data_out, T2);
        chk("dec_cv", ctrl_valid, 1);
        chk("dec_ctrl", ctrl, 2'b10);
        step(10'h000, 1'b1);
        chk("dec_nt_data", data_out, 10'h155);
        chk("dec_nt_cv", ctrl_valid, 0);
        chk("dec_nt_ctrl", ctrl, 0);

        // reset while locked at offset 5, then relock
        step(10'h000, 1'b0);
        psym = '0;
        n = 0;
        while (!locked && n < 200) begin
            send_skew(T3, 5);
            n++;
        end
        chk("off5_lock", locked, 1);
        chk("off5_offset", offset, 5);
        step(skew(T3, psym, 5), 1'b0);
        psym = T3;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_offset", offset, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_cv", ctrl_valid, 0);
        n = 0;
        while (!locked && n < 200) begin
            send_skew(T3, 5);
            n++;
        end
        chk("relock", locked, 1);
        chk("relock_offset", offset, 5);

        // random soak against the model
        step(10'h000, 1'b0);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: d = T0;
                1: d = ($urandom_range(0, 1)) ? T1 : T3;
                default: d = 10'($urandom_range(0, 1023));
            endcase
            step(d, ($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_word_align.md
Name: tmds_word_align

Overview:
- Receive-side counterpart of the 10:1 TMDS output serializer; sits after a 1:10 input deserializer, in the pixel-clock domain, one instance per TMDS channel.
- Recovers the 10-bit symbol boundary by searching bit offsets 0-9 for runs of TMDS control tokens, then outputs aligned symbols.
- Also reports lock status and decodes control tokens.

Parameters:
- LOCK_CNT, 8: consecutive control tokens at one offset required to declare lock.
- SEARCH_WAIT, 4096: cycles spent at each offset before advancing; must exceed one blanking interval.
- LOSS_WAIT, 65536: cycles in lock without a qualifying token run before lock is dropped.

Ports:
- clk  input  1  pixel clock (parallel word clock).
- rst_n  input  1  reset; synchronous and active-low.
- data_in  input  10  unaligned parallel word from the deserializer; bit 0 was received first.
- data_out  output  10  aligned TMDS symbol.
- ctrl_valid  output  1  data_out is one of the four control tokens.
- ctrl  output  2  decoded control bits {c1,c0} when ctrl_valid=1, else 0.
- locked  output  1  alignment found.
- offset  output  4  current bit offset, 0-9.

Behaviour:
- Reset (rst_n=0 at a clk edge): data_out=0, ctrl_valid=0, ctrl=0, locked=0, offset=0, prev=0, state=SEARCH, all counters=0. Reset mid-operation behaves identically and discards all state.
- Every cycle: prev<=data_in. cat={data_in,prev} (20 bits). Selected word w=cat[offset+9:offset].
- Offset 0 selects prev (bits received first).
- data_out<=w; ctrl_valid and ctrl are registered from w in the same cycle.
- Latency from data_in to data_out is 2 cycles.
- Tokens, as q[9:0]:
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- run_cnt: incremented when w is a token, cleared otherwise; saturates at LOCK_CNT.
- State SEARCH:
  - dwell increments every cycle.
  - If run_cnt+1 reaches LOCK_CNT on a token: go to LOCKED, locked<=1, dwell=0, loss=0.
  - Else if dwell==SEARCH_WAIT-1: offset<=(offset==9)?0:offset+1, dwell=0, run_cnt=0.
  - If lock and advance coincide, lock wins and offset is not changed.
- State LOCKED:
  - offset is frozen.
  - loss increments each cycle and clears whenever run_cnt reaches LOCK_CNT.
  - If loss==LOSS_WAIT-1: go to SEARCH, locked<=0, run_cnt=dwell=loss=0, offset kept; the search resumes from the current offset.
- After an offset change, data_out switches to the new offset the next cycle. There is no flush; one mixed word is tolerated while unlocked.
- Counter widths: $clog2 of each limit. The 4-bit offset never takes values 10-15.

Decomposition:
- Shared package tmds_pkg:
  - the four control-token constants (as 10-bit localparams) and their ctrl codes;
  - state enum {SEARCH, LOCKED}.
- Natural sub-module: bitslip_10b, the combinational 20-to-10 offset selector, reusable by other receive blocks.
- Token match is a package function.

Test Plan (LOCK_CNT=4, SEARCH_WAIT=16, LOSS_WAIT=64):
- Aligned stream: four words of 1101010100 followed by data words -> offset stays 0; locked rises exactly 2 cycles after the 4th token is presented; data_out equals input delayed 2 cycles.
- Stream skewed by 3 bits with a repeating 4-token run every 12 cycles -> offset steps 0->1->2->3 every 16 cycles, then locks at offset=3; locked rises 2 cycles after the 4th token following the offset=3 step.
- After lock, feed 1010101010 continuously -> locked falls exactly 64 cycles after the last qualifying token run; offset unchanged; dwell restarts.
- Runs of 3 tokens, 1 data word, repeated forever -> never locks; offset wraps 9->0 after 160 cycles.
- Input 0101010100 at offset 0 -> 2 cycles later data_out=0101010100, ctrl_valid=1, ctrl=2'b10. Input 0x155 -> ctrl_valid=0, ctrl=0.
- While locked at offset 5, hold rst_n=0 for one edge -> next cycle locked=0, offset=0, data_out=0, ctrl_valid=0; normal relock follows.
